// File: rtl/branch_cond_unit.sv
// Resolves conditional branch/call requests against the ZCSO flags, waiting out pending flag writes.
// Accept -> decision one cycle later, plus one cycle per pending flag write; a forced resolve follows MAX_WAIT waits.
module branch_cond_unit #(
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        zcso,
  input  logic              flag_upd_pend,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cond,
  input  logic [ADDR_W-1:0] req_target,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic              req_link,
  output logic              br_valid,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_target,
  output logic              br_illegal,
  output logic              br_timeout,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic [CNT_W-1:0]  taken_count
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_FLAGS, RESOLVE} state_t;

  state_t              r_state;
  logic [3:0]          r_cond;
  logic [ADDR_W-1:0]   r_target;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_link;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_taken_count;

  logic                w_z, w_c, w_s, w_o, w_lt;
  logic                w_cond_true;
  logic                w_illegal;
  logic                w_resolve;
  logic                w_taken;
  logic [WCNT_W-1:0]   w_wait_next;

  assign w_z  = zcso[0];
  assign w_c  = zcso[1];
  assign w_s  = zcso[2];
  assign w_o  = zcso[3];
  assign w_lt = w_s ^ w_o;

  // Flags are evaluated live in the RESOLVE cycle, never at accept.
  always_comb begin
    w_cond_true = 1'b0;
    w_illegal   = 1'b0;
    case (r_cond)
      4'b0000: w_cond_true = 1'b1;
      4'b0001: w_cond_true = w_z;
      4'b0010: w_cond_true = ~w_z;
      4'b0011: w_cond_true = w_c;
      4'b0100: w_cond_true = ~w_c;
      4'b0101: w_cond_true = w_s;
      4'b0110: w_cond_true = ~w_s;
      4'b0111: w_cond_true = w_o;
      4'b1000: w_cond_true = ~w_o;
      4'b1001: w_cond_true = w_lt;
      4'b1010: w_cond_true = ~w_lt;
      4'b1011: w_cond_true = ~w_z & ~w_lt;
      4'b1100: w_cond_true = w_z | w_lt;
      default: w_illegal   = 1'b1;
    endcase
  end

  assign w_resolve   = (r_state == RESOLVE);
  assign w_taken     = w_resolve & w_cond_true & ~w_illegal;
  assign w_wait_next = r_wait_cnt + WCNT_W'(1);

  assign req_ready   = (r_state == IDLE) & ~reset;
  assign br_valid    = w_resolve;
  assign br_taken    = w_taken;
  assign br_target   = w_resolve ? r_target : '0;
  assign br_illegal  = w_resolve & w_illegal;
  assign br_timeout  = w_resolve & r_timeout;
  assign link_we     = w_taken & r_link;
  assign link_data   = w_resolve ? (r_pc + ADDR_W'(1)) : '0;
  assign taken_count = r_taken_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cond        <= '0;
      r_target      <= '0;
      r_pc          <= '0;
      r_link        <= 1'b0;
      r_wait_cnt    <= '0;
      r_timeout     <= 1'b0;
      r_taken_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_cond     <= req_cond;
            r_target   <= req_target;
            r_pc       <= req_pc;
            r_link     <= req_link;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
            r_state    <= flag_upd_pend ? WAIT_FLAGS : RESOLVE;
          end
        end
        WAIT_FLAGS: begin
          if (!flag_upd_pend) begin
            r_state <= RESOLVE;
          end else begin
            r_wait_cnt <= w_wait_next;
            if (w_wait_next == WCNT_W'(MAX_WAIT)) begin
              r_timeout <= 1'b1;
              r_state   <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          if (w_taken && (r_taken_count != '1))
            r_taken_count <= r_taken_count + CNT_W'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
